conv_result_reader: RTL and testbench



---
 rtl/conv_result_reader_if.sv | 28 ++
 rtl/conv_result_reader.sv | 100 ++++++++++
 tb/tb_conv_result_reader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/conv_result_reader_if.sv
// Handshake bundle between the result reader, the output-buffer read port
// and the downstream consumer of result words.
interface conv_result_reader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);
  logic              start;
  logic [ADDR_W:0]   count;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              done;

  modport master (
    input  start, count, mem_rdata, out_ready,
    output mem_rd, mem_addr, out_data, out_valid, out_last, busy, done
  );

  modport slave (
    output start, count, mem_rdata, out_ready,
    input  mem_rd, mem_addr, out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/conv_result_reader.sv
// Drains the convolution output buffer: reads cnt words from address 0 and
// hands each one downstream over valid/ready, pulsing done after the last.
module conv_result_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_result_reader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    SEND,
    FIN
  } state_t;

  localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   idx_reg, idx_next;
  logic [ADDR_W:0]   cnt_reg, cnt_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [ADDR_W:0]   cnt_sat;
  logic              is_last;

  assign cnt_sat = (bus.count > MAX_CNT) ? MAX_CNT : bus.count;
  // cnt_reg is never 0 while in SEND, so the subtraction cannot underflow there
  assign is_last = (idx_reg == (cnt_reg - ONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          cnt_next   = cnt_sat;
          idx_next   = '0;
          state_next = (cnt_sat == '0) ? FIN : ISSUE;
        end
      end
      ISSUE:   state_next = CAPTURE;
      CAPTURE: begin
        data_next  = bus.mem_rdata;
        state_next = SEND;
      end
      SEND: begin
        if (bus.out_ready) begin
          idx_next   = idx_reg + ONE;
          state_next = is_last ? FIN : ISSUE;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Every output is a decode of registered state, never of start or out_ready.
  always_comb begin
    bus.mem_rd    = 1'b0;
    bus.mem_addr  = '0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.busy      = (state_reg != IDLE);
    bus.done      = 1'b0;
    bus.out_data  = data_reg;
    case (state_reg)
      ISSUE: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = idx_reg[ADDR_W-1:0];
      end
      SEND: begin
        bus.out_valid = 1'b1;
        bus.out_last  = is_last;
      end
      FIN:     bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conv_result_reader.sv
// Scoreboarded bench: runs push expected words/addresses, a negedge monitor
// pops and compares them as the reader issues reads and transfers words.
module tb_conv_result_reader;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  conv_result_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  conv_result_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
  end

  int checks   = 0;
  int failures = 0;

  logic [DATA_W:0] exp_q [$];
  int              addr_q [$];

  int t0;
  int rel;
  int rd_cnt, xfer_cnt, done_cnt;
  int first_rd_rel, first_valid_rel, done_rel;
  bit timed;
  bit prev_stall;
  logic [DATA_W-1:0] prev_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [DATA_W:0] e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      rel = cyc - t0;
      if (bus.mem_rd) begin
        rd_cnt++;
        if (first_rd_rel < 0) first_rd_rel = rel;
        if (addr_q.size() == 0) chk("unexpected_mem_rd", 64'(bus.mem_addr), 64'hFFFF);
        else chk("mem_addr", 64'(bus.mem_addr), 64'(addr_q.pop_front()));
      end else begin
        chk("mem_addr_idle", 64'(bus.mem_addr), 64'd0);
      end
      if (bus.out_valid) begin
        if (first_valid_rel < 0) first_valid_rel = rel;
        if (prev_stall) chk("hold_data", 64'(bus.out_data), 64'(prev_data));
        if (bus.out_ready) begin
          xfer_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_xfer", 64'(bus.out_data), 64'hFFFF);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", 64'(bus.out_data), 64'(e[DATA_W-1:0]));
            chk("out_last", 64'(bus.out_last), 64'(e[DATA_W]));
          end
          if (timed) chk("xfer_cycle", 64'(rel), 64'(3 * xfer_cnt));
          $display("xfer %0d data=%h last=%b cycle=%0d", xfer_cnt, bus.out_data, bus.out_last, rel);
        end
      end else begin
        if (prev_stall) chk("valid_dropped", 64'(bus.out_valid), 64'd1);
        if (bus.out_last) chk("last_without_valid", 64'(bus.out_last), 64'd0);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (bus.done) begin
        done_cnt++;
        done_rel = rel;
      end
    end
  end

  task automatic start_run(input int c, input int n_exp, input bit timed_i);
    for (int i = 0; i < n_exp; i++) begin
      exp_q.push_back({(i == n_exp - 1), mem[i]});
      addr_q.push_back(i);
    end
    rd_cnt = 0; xfer_cnt = 0; done_cnt = 0;
    first_rd_rel = -1; first_valid_rel = -1; done_rel = -1;
    timed = timed_i;
    bus.count = (ADDR_W + 1)'(c);
    bus.start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(input int bound);
    int k = 0;
    while (!bus.out_valid && k < bound) begin
      @(posedge clk); #1;
      k++;
    end
    chk("valid_timeout", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (done_cnt == 0 && k < bound) begin
      @(posedge clk); #1;
      k++;
    end
    chk("done_seen", 64'(done_cnt), 64'd1);
    chk("busy_after_done", 64'(bus.busy), 64'd0);
  endtask

  task automatic end_checks(input int n_xfer, input int n_rd, input int exp_done_rel);
    repeat (3) begin @(posedge clk); #1; end
    chk("xfer_count", 64'(xfer_cnt), 64'(n_xfer));
    chk("rd_count", 64'(rd_cnt), 64'(n_rd));
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("addr_q_empty", 64'(addr_q.size()), 64'd0);
    if (exp_done_rel >= 0) chk("done_cycle", 64'(done_rel), 64'(exp_done_rel));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_rd"}, 64'(bus.mem_rd), 64'd0);
    chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_out_last"}, 64'(bus.out_last), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_out_data"}, 64'(bus.out_data), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'((i + 1) * 16'h0011);
    bus.start = 1'b0;
    bus.count = '0;
    bus.out_ready = 1'b0;
    t0 = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_all_zero("post_reset");

    // Basic drain with out_ready held high
    bus.out_ready = 1'b1;
    start_run(4, 4, 1'b1);
    wait_done(40);
    end_checks(4, 4, 13);
    chk("basic_first_rd", 64'(first_rd_rel), 64'd1);
    chk("basic_first_valid", 64'(first_valid_rel), 64'd3);

    // Backpressure: first word stalled for 5 cycles
    bus.out_ready = 1'b0;
    start_run(2, 2, 1'b0);
    wait_valid(20);
    repeat (5) begin @(posedge clk); #1; end
    chk("bp_rd_during_stall", 64'(rd_cnt), 64'd1);
    chk("bp_valid_held", 64'(bus.out_valid), 64'd1);
    chk("bp_data_held", 64'(bus.out_data), 64'h0011);
    bus.out_ready = 1'b1;
    wait_done(40);
    end_checks(2, 2, -1);

    // Zero count
    start_run(0, 0, 1'b1);
    wait_done(10);
    end_checks(0, 0, 1);
    chk("zero_no_rd", 64'(first_rd_rel), 64'(-1));
    chk("zero_no_valid", 64'(first_valid_rel), 64'(-1));

    // Saturation: 70 requested, 64 delivered, addresses 0..63
    start_run(70, 64, 1'b1);
    wait_done(400);
    end_checks(64, 64, 3 * 64 + 1);

    // Start during SEND is ignored
    start_run(3, 3, 1'b1);
    wait_valid(20);
    bus.start = 1'b1;
    bus.count = 7'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(60);
    end_checks(3, 3, 10);

    // Reset while a word is stalled in SEND
    bus.out_ready = 1'b0;
    start_run(4, 4, 1'b0);
    wait_valid(20);
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    exp_q.delete();
    addr_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy_after", 64'(bus.busy), 64'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_no_done", 64'(done_cnt), 64'd0);
    bus.out_ready = 1'b1;
    start_run(4, 4, 1'b1);
    wait_done(40);
    end_checks(4, 4, 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
